// File: rtl/big_adder_pkg.sv
// big_adder_pkg: shared stage payload type and pipeline sizing for big_adder_pipe
package big_adder_pkg;
  localparam int MAX_CHUNK = 64;
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [MAX_CHUNK-1:0] slice;
  } stage_t;
  function automatic int stages_of(input int width, input int chunk);
    return width / chunk;
  endfunction
endpackage

// File: rtl/big_adder_stage.sv
// big_adder_stage: one registered CHUNK-bit adder slice holding its carry and valid bit
module big_adder_stage
  import big_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_in,
  input  logic             carry_in,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             valid,
  output logic             carry,
  output logic [CHUNK-1:0] slice
);
  stage_t r;
  logic [CHUNK:0] sum;
  assign sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carry_in};
  always_ff @(posedge clk)
    if (rst) r <= '0;
    else if (en) r <= '{valid: valid_in, carry: sum[CHUNK], slice: MAX_CHUNK'(sum[CHUNK-1:0])};
  assign valid = r.valid;
  assign carry = r.carry;
  assign slice = r.slice[CHUNK-1:0];
endmodule

// File: rtl/big_adder_pipe.sv
// big_adder_pipe: pipelined CHUNK-per-stage add/sub with valid/ready, ovf via BIG_ADDER_PIPE_OVF_EN
module big_adder_pipe
  import big_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] so,
  output logic             c_out
`ifdef BIG_ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int STAGES = stages_of(WIDTH, CHUNK);
  logic advance;
  logic [WIDTH-1:0] b_eff;
  logic [STAGES-1:0] v, cy, v_src, c_src;
  logic [CHUNK-1:0] sl [STAGES];
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] d_src [STAGES];
  logic [WIDTH-1:0] a_sk [STAGES];
  logic [WIDTH-1:0] b_sk [STAGES];
  logic [WIDTH-1:0] dk [STAGES];
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff = sub ? ~b_in : b_in;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_head
      assign a_src[k] = a_in;
      assign b_src[k] = b_eff;
      assign c_src[k] = sub | c_in;
      assign v_src[k] = in_valid;
      assign d_src[k] = '0;
    end else begin : g_tail
      assign a_src[k] = a_sk[k-1];
      assign b_src[k] = b_sk[k-1];
      assign c_src[k] = cy[k-1];
      assign v_src[k] = v[k-1];
      assign d_src[k] = dk[k-1] | (WIDTH'(sl[k-1]) << ((k - 1) * CHUNK));
    end
    big_adder_stage #(.CHUNK(CHUNK)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (advance),
      .valid_in (v_src[k]),
      .carry_in (c_src[k]),
      .a        (a_src[k][k*CHUNK +: CHUNK]),
      .b        (b_src[k][k*CHUNK +: CHUNK]),
      .valid    (v[k]),
      .carry    (cy[k]),
      .slice    (sl[k])
    );
    always_ff @(posedge clk)
      if (rst) begin
        a_sk[k] <= '0;
        b_sk[k] <= '0;
        dk[k]   <= '0;
      end else if (advance) begin
        a_sk[k] <= a_src[k];
        b_sk[k] <= b_src[k];
        dk[k]   <= d_src[k];
      end
  end
  assign out_valid = v[STAGES-1];
  assign c_out = cy[STAGES-1];
  assign so = dk[STAGES-1] | (WIDTH'(sl[STAGES-1]) << ((STAGES - 1) * CHUNK));
`ifdef BIG_ADDER_PIPE_OVF_EN
  assign ovf = (a_sk[STAGES-1][WIDTH-1] == b_sk[STAGES-1][WIDTH-1]) && (so[WIDTH-1] != a_sk[STAGES-1][WIDTH-1]);
`endif
endmodule

// File: tb/tb_big_adder_pipe.sv
// tb_big_adder_pipe: directed and random checks of big_adder_pipe at 16/4 and 32/8
module tb_big_adder_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
  logic [15:0] a_in, b_in, so;
  logic in_valid2, in_ready2, c_in2, sub2, out_valid2, out_ready2, c_out2;
  logic [31:0] a_in2, b_in2, so2;
`ifdef BIG_ADDER_PIPE_OVF_EN
  logic ovf, ovf2;
`endif
  big_adder_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .so(so), .c_out(c_out)
`ifdef BIG_ADDER_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );
  big_adder_pipe #(.WIDTH(32), .CHUNK(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a_in(a_in2), .b_in(b_in2), .c_in(c_in2), .sub(sub2),
    .out_valid(out_valid2), .out_ready(out_ready2), .so(so2), .c_out(c_out2)
`ifdef BIG_ADDER_PIPE_OVF_EN
    , .ovf(ovf2)
`endif
  );
  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;
  exp_t q[$];
  exp_t q2[$];
  int pass_cnt = 0, fail_cnt = 0, total = 0, cyc = 0, stall_lo = 0, stall_hi = 0;
  bit chk_lat = 1'b1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    logic st;
    logic [15:0] s0;
    exp_t e;
    st = out_valid & ~out_ready;
    s0 = so;
    if (out_valid & out_ready) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else begin
        e = q.pop_front();
        chk("so", 64'(so), 64'(e.s[15:0]));
        chk("c_out", 64'(c_out), 64'(e.c));
`ifdef BIG_ADDER_PIPE_OVF_EN
        chk("ovf", 64'(ovf), 64'(e.o));
`endif
        if (chk_lat) chk("latency", 64'(cyc + 1 - e.acc), 64'd4);
      end
    end
    @(posedge clk);
    #2;
    cyc++;
    if (st) begin
      chk("hold_so", 64'(so), 64'(s0));
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = !(cyc >= stall_lo && cyc < stall_hi);
  endtask
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                      input logic [15:0] es, input logic ec, input logic eo);
    bit done;
    done = 1'b0;
    a_in = a;
    b_in = b;
    c_in = ci;
    sub = sb;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (in_ready) begin
        q.push_back('{s: 32'(es), c: ec, o: eo, acc: cyc + 1});
        done = 1'b1;
      end
      tick;
    end
    chk("accept_timeout", 64'(done), 64'd1);
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick;
  endtask
  task automatic tick2;
    logic st;
    logic [31:0] s0;
    exp_t e;
    st = out_valid2 & ~out_ready2;
    s0 = so2;
    if (out_valid2 & out_ready2) begin
      if (q2.size() == 0) chk("spurious_out2", 64'(out_valid2), 64'd0);
      else begin
        e = q2.pop_front();
        chk("so2", 64'(so2), 64'(e.s));
        chk("c_out2", 64'(c_out2), 64'(e.c));
`ifdef BIG_ADDER_PIPE_OVF_EN
        chk("ovf2", 64'(ovf2), 64'(e.o));
`endif
      end
    end
    @(posedge clk);
    #2;
    cyc++;
    if (st) begin
      chk("hold_so2", 64'(so2), 64'(s0));
      chk("stall_in_ready2", 64'(in_ready2), 64'd0);
    end
    out_ready2 = ($urandom_range(3) != 0);
  endtask
  task automatic send2(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
    bit done;
    logic [31:0] be;
    logic [32:0] r;
    done = 1'b0;
    be = sb ? ~b : b;
    r = {1'b0, a} + {1'b0, be} + 33'(sb | ci);
    a_in2 = a;
    b_in2 = b;
    c_in2 = ci;
    sub2 = sb;
    in_valid2 = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (in_ready2) begin
        q2.push_back('{s: r[31:0], c: r[32], o: (a[31] == be[31]) && (r[31] != a[31]), acc: cyc + 1});
        done = 1'b1;
      end
      tick2;
    end
    chk("accept_timeout2", 64'(done), 64'd1);
    in_valid2 = 1'b0;
  endtask
  task automatic idle2(input int n);
    in_valid2 = 1'b0;
    repeat (n) tick2;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    a_in = 16'h1111;
    b_in = 16'h2222;
    c_in = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    in_valid2 = 1'b1;
    a_in2 = 32'h1234_5678;
    b_in2 = 32'h1111_1111;
    c_in2 = 1'b0;
    sub2 = 1'b0;
    out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_so", 64'(so), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
`ifdef BIG_ADDER_PIPE_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    chk("rst_out_valid2", 64'(out_valid2), 64'd0);
    chk("rst_so2", 64'(so2), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_in_ready2", 64'(in_ready2), 64'd1);
    idle(5);
    chk("no_ghost_after_rst", 64'(out_valid), 64'd0);
    send(16'hF0F0, 16'h0F0F, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    send(16'hE2A1, 16'h1234, 1'b0, 1'b0, 16'hF4D5, 1'b0, 1'b0);
    send(16'h1E3B, 16'h2024, 1'b0, 1'b0, 16'h3E5F, 1'b0, 1'b0);
    send(16'h2AFB, 16'h0144, 1'b0, 1'b0, 16'h2C3F, 1'b0, 1'b0);
    idle(6);
    chk("drain_b2b", 64'(q.size()), 64'd0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h1234, 16'hE2A1, 1'b1, 1'b1, 16'h2F93, 1'b0, 1'b0);
    send(16'hE2A1, 16'h1234, 1'b0, 1'b1, 16'hD06D, 1'b1, 1'b0);
    idle(6);
    chk("drain_carry", 64'(q.size()), 64'd0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
    idle(6);
    chk("drain_ovf", 64'(q.size()), 64'd0);
    chk_lat = 1'b0;
    stall_lo = cyc + 4;
    stall_hi = cyc + 8;
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    send(16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0);
    idle(10);
    chk("drain_backpressure", 64'(q.size()), 64'd0);
    chk_lat = 1'b1;
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    send(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
    send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
    idle(1);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    rst = 1'b1;
    in_valid = 1'b1;
    a_in = 16'h5555;
    q.delete();
    @(posedge clk);
    #2;
    cyc++;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_so", 64'(so), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("no_stale_valid", 64'(out_valid), 64'd0);
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    idle(6);
    chk("drain_after_rst", 64'(q.size()), 64'd0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) idle2(1);
      send2($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    send2(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send2(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send2(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    idle2(12);
    out_ready2 = 1'b1;
    idle2(0);
    send2($urandom, $urandom, 1'b0, 1'b0);
    send2($urandom, $urandom, 1'b1, 1'b1);
    rst = 1'b1;
    in_valid2 = 1'b1;
    q2.delete();
    @(posedge clk);
    #2;
    cyc++;
    chk("mid_rst_out_valid2", 64'(out_valid2), 64'd0);
    rst = 1'b0;
    in_valid2 = 1'b0;
    idle2(6);
    for (int i = 0; i < 10; i++) send2($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    idle2(16);
    chk("drain_w32", 64'(q2.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
